// File: rtl/sd_pad_bank.sv
// Bank of bidirectional SD pad lanes with shared direction control,
// registered drive, input synchroniser and bus-release turnaround.
module sd_pad_bank #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int TURN_CYCLES = 2,
   parameter int OPEN_DRAIN  = 0
) (
   input  logic             sd_clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             output_input,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   input  logic [WIDTH-1:0] pad_in,
   output logic [WIDTH-1:0] pad_out,
   output logic [WIDTH-1:0] pad_oe,
   output logic             dir_ready
);

   localparam int CW = (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;
   localparam int LOAD_I = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;
   localparam logic [CW-1:0] CNT_LOAD = CW'(LOAD_I);

   typedef enum logic [1:0] {
      RX      = 2'd0,
      TURN_TX = 2'd1,
      TX      = 2'd2,
      TURN_RX = 2'd3
   } state_t;

   state_t state;
   state_t state_next;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic [WIDTH-1:0] oe_next;
   logic [WIDTH-1:0] out_next;
   logic rdy_next;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];

   logic drive_req;
   assign drive_req = enable && output_input;

   always_ff @(posedge sd_clock) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '1;
         end
      end else begin
         sync_q[0] <= pad_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      unique case (state)
         RX: begin
            if (drive_req) begin
               if (TURN_CYCLES == 0) begin
                  state_next = TX;
               end else begin
                  state_next = TURN_TX;
                  cnt_next   = CNT_LOAD;
               end
            end
         end
         TURN_TX: begin
            if (!drive_req) begin
               state_next = RX;
            end else if (cnt == '0) begin
               state_next = TX;
            end else begin
               cnt_next = cnt - CW'(1);
            end
         end
         TX: begin
            if (!drive_req) begin
               if (TURN_CYCLES == 0) begin
                  state_next = RX;
               end else begin
                  state_next = TURN_RX;
                  cnt_next   = CNT_LOAD;
               end
            end
         end
         TURN_RX: begin
            // Release is unconditional; requests wait until RX.
            if (cnt == '0) begin
               state_next = RX;
            end else begin
               cnt_next = cnt - CW'(1);
            end
         end
         default: begin
            state_next = RX;
            cnt_next   = '0;
         end
      endcase
   end

   // Outputs register off the next state so the pads switch on the same edge.
   always_comb begin
      oe_next  = '0;
      out_next = '1;
      rdy_next = (state_next == RX) || (state_next == TX);
      if (state_next == TX) begin
         if (OPEN_DRAIN != 0) begin
            oe_next  = ~data_in;
            out_next = '0;
         end else begin
            oe_next  = '1;
            out_next = data_in;
         end
      end
   end

   always_ff @(posedge sd_clock) begin
      if (reset) begin
         state     <= RX;
         cnt       <= '0;
         pad_oe    <= '0;
         pad_out   <= '1;
         dir_ready <= 1'b1;
         data_out  <= '1;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         pad_oe    <= oe_next;
         pad_out   <= out_next;
         dir_ready <= rdy_next;
         if (state == RX) begin
            data_out <= sync_q[SYNC_STAGES-1];
         end
      end
   end

endmodule

// File: tb/tb_sd_pad_bank.sv
// Directed vector bench for sd_pad_bank: push-pull, open-drain
// and zero-turnaround instances driven from shared inputs.
module tb_sd_pad_bank;

   logic clk = 1'b0;
   logic reset;
   logic enable;
   logic output_input;
   logic [3:0] data_in;
   logic [3:0] pad_in;

   logic [3:0] a_dout, a_out, a_oe;
   logic       a_rdy;
   logic [3:0] o_dout, o_out, o_oe;
   logic       o_rdy;
   logic [3:0] z_dout, z_out, z_oe;
   logic       z_rdy;

   int n_tests = 0;
   int n_fail  = 0;
   logic mon_on = 1'b0;

   always #5 clk = ~clk;

   sd_pad_bank #(.WIDTH(4), .SYNC_STAGES(2), .TURN_CYCLES(2), .OPEN_DRAIN(0)) dut_a (
      .sd_clock(clk), .reset(reset), .enable(enable),
      .output_input(output_input), .data_in(data_in), .data_out(a_dout),
      .pad_in(pad_in), .pad_out(a_out), .pad_oe(a_oe), .dir_ready(a_rdy)
   );

   sd_pad_bank #(.WIDTH(4), .SYNC_STAGES(2), .TURN_CYCLES(2), .OPEN_DRAIN(1)) dut_od (
      .sd_clock(clk), .reset(reset), .enable(enable),
      .output_input(output_input), .data_in(data_in), .data_out(o_dout),
      .pad_in(pad_in), .pad_out(o_out), .pad_oe(o_oe), .dir_ready(o_rdy)
   );

   sd_pad_bank #(.WIDTH(4), .SYNC_STAGES(2), .TURN_CYCLES(0), .OPEN_DRAIN(0)) dut_z (
      .sd_clock(clk), .reset(reset), .enable(enable),
      .output_input(output_input), .data_in(data_in), .data_out(z_dout),
      .pad_in(pad_in), .pad_out(z_out), .pad_oe(z_oe), .dir_ready(z_rdy)
   );

   typedef struct {
      logic       rst;
      logic       en;
      logic       oi;
      logic [3:0] din;
      logic [3:0] pin;
      logic [3:0] oe;
      logic [3:0] out;
      logic [3:0] dout;
      logic       rdy;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic en, input logic oi,
                      input logic [3:0] din, input logic [3:0] pin,
                      input logic [3:0] oe, input logic [3:0] out,
                      input logic [3:0] dout, input logic rdy);
      vec_t v;
      v.rst = rst; v.en = en; v.oi = oi; v.din = din; v.pin = pin;
      v.oe = oe; v.out = out; v.dout = dout; v.rdy = rdy;
      vecs.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [3:0] got,
                      input logic [3:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %b want %b", name, got, want);
      end
   endtask

   // Drive is only legal in TX, where dir_ready is high.
   always @(negedge clk) begin
      if (mon_on) begin
         n_tests++;
         if ((!a_rdy && a_oe != 4'b0) || (!o_rdy && o_oe != 4'b0)) begin
            n_fail++;
            $display("FAIL turnaround_drive: a_oe=%b a_rdy=%b o_oe=%b o_rdy=%b want oe=0000 when not ready",
                     a_oe, a_rdy, o_oe, o_rdy);
         end
      end
   end

   initial begin
      reset = 1'b1; enable = 1'b0; output_input = 1'b0;
      data_in = 4'h0; pad_in = 4'hF;

      //   rst en oi din    pin    oe     out    dout   rdy
      add(1, 0, 0, 4'h0, 4'hF, 4'h0, 4'hF, 4'hF, 1);
      add(1, 0, 0, 4'h0, 4'hF, 4'h0, 4'hF, 4'hF, 1);
      add(1, 0, 0, 4'h0, 4'hF, 4'h0, 4'hF, 4'hF, 1);
      add(0, 1, 1, 4'hA, 4'hF, 4'h0, 4'hF, 4'hF, 0);
      add(0, 1, 1, 4'hA, 4'hF, 4'h0, 4'hF, 4'hF, 0);
      add(0, 1, 1, 4'hA, 4'hF, 4'hF, 4'hA, 4'hF, 1);
      add(0, 1, 1, 4'h5, 4'hF, 4'hF, 4'h5, 4'hF, 1);
      add(0, 1, 1, 4'h5, 4'h6, 4'hF, 4'h5, 4'hF, 1);
      add(0, 1, 0, 4'h5, 4'h6, 4'h0, 4'hF, 4'hF, 0);
      add(0, 1, 0, 4'h5, 4'h6, 4'h0, 4'hF, 4'hF, 0);
      add(0, 1, 0, 4'h5, 4'h6, 4'h0, 4'hF, 4'hF, 1);
      add(0, 1, 0, 4'h5, 4'h6, 4'h0, 4'hF, 4'h6, 1);
      add(0, 1, 0, 4'h5, 4'h9, 4'h0, 4'hF, 4'h6, 1);
      add(0, 1, 0, 4'h5, 4'h9, 4'h0, 4'hF, 4'h6, 1);
      add(0, 1, 0, 4'h5, 4'h9, 4'h0, 4'hF, 4'h9, 1);
      add(0, 1, 1, 4'h5, 4'h9, 4'h0, 4'hF, 4'h9, 0);
      add(0, 1, 0, 4'h5, 4'h9, 4'h0, 4'hF, 4'h9, 1);
      add(0, 1, 0, 4'h5, 4'h9, 4'h0, 4'hF, 4'h9, 1);
      add(0, 1, 1, 4'hA, 4'h9, 4'h0, 4'hF, 4'h9, 0);
      add(0, 1, 1, 4'hA, 4'h9, 4'h0, 4'hF, 4'h9, 0);
      add(0, 1, 1, 4'hA, 4'h9, 4'hF, 4'hA, 4'h9, 1);
      add(0, 1, 0, 4'hA, 4'h9, 4'h0, 4'hF, 4'h9, 0);
      add(0, 1, 1, 4'hA, 4'h9, 4'h0, 4'hF, 4'h9, 0);
      add(0, 1, 1, 4'hA, 4'h9, 4'h0, 4'hF, 4'h9, 1);
      add(0, 1, 1, 4'hA, 4'h9, 4'h0, 4'hF, 4'h9, 0);
      add(0, 1, 1, 4'hA, 4'h9, 4'h0, 4'hF, 4'h9, 0);
      add(0, 1, 1, 4'hA, 4'h9, 4'hF, 4'hA, 4'h9, 1);
      add(0, 0, 1, 4'hA, 4'h9, 4'h0, 4'hF, 4'h9, 0);
      add(0, 0, 1, 4'hA, 4'h9, 4'h0, 4'hF, 4'h9, 0);
      add(0, 0, 1, 4'hA, 4'h9, 4'h0, 4'hF, 4'h9, 1);
      add(0, 0, 1, 4'hA, 4'h9, 4'h0, 4'hF, 4'h9, 1);
      add(0, 1, 1, 4'hA, 4'h9, 4'h0, 4'hF, 4'h9, 0);
      add(0, 1, 1, 4'hA, 4'h9, 4'h0, 4'hF, 4'h9, 0);
      add(0, 1, 1, 4'hA, 4'h9, 4'hF, 4'hA, 4'h9, 1);
      add(1, 1, 1, 4'hA, 4'h9, 4'h0, 4'hF, 4'hF, 1);
      add(0, 1, 0, 4'hA, 4'h9, 4'h0, 4'hF, 4'hF, 1);
      add(0, 1, 0, 4'hA, 4'h9, 4'h0, 4'hF, 4'hF, 1);
      add(0, 1, 0, 4'hA, 4'h9, 4'h0, 4'hF, 4'h9, 1);

      foreach (vecs[i]) begin
         reset        = vecs[i].rst;
         enable       = vecs[i].en;
         output_input = vecs[i].oi;
         data_in      = vecs[i].din;
         pad_in       = vecs[i].pin;
         step();
         if (i == 2) mon_on = 1'b1;
         chk($sformatf("v%0d_oe", i), a_oe, vecs[i].oe);
         chk($sformatf("v%0d_out", i), a_out, vecs[i].out);
         chk($sformatf("v%0d_dout", i), a_dout, vecs[i].dout);
         chk($sformatf("v%0d_rdy", i), {3'b0, a_rdy}, {3'b0, vecs[i].rdy});
      end

      // Open-drain: low data bits enable the pull-down.
      enable = 1'b1; output_input = 1'b1; data_in = 4'b1100;
      step();
      chk("od_turn1_rdy", {3'b0, o_rdy}, 4'h0);
      step();
      chk("od_turn2_oe", o_oe, 4'b0000);
      step();
      chk("od_tx_oe", o_oe, 4'b0011);
      chk("od_tx_out", o_out, 4'b0000);
      chk("od_tx_rdy", {3'b0, o_rdy}, 4'h1);
      enable = 1'b0;
      step();
      chk("od_dis_oe", o_oe, 4'b0000);
      chk("od_dis_out", o_out, 4'b1111);
      chk("od_dis_rdy", {3'b0, o_rdy}, 4'h0);
      step();
      chk("od_dis2_rdy", {3'b0, o_rdy}, 4'h0);
      step();
      chk("od_rx_rdy", {3'b0, o_rdy}, 4'h1);
      chk("od_rx_oe", o_oe, 4'b0000);

      // Zero-turnaround instance switches in a single edge both ways.
      chk("z_idle_rdy", {3'b0, z_rdy}, 4'h1);
      enable = 1'b1; output_input = 1'b1; data_in = 4'b1010;
      step();
      chk("z_tx_oe", z_oe, 4'b1111);
      chk("z_tx_out", z_out, 4'b1010);
      chk("z_tx_rdy", {3'b0, z_rdy}, 4'h1);
      output_input = 1'b0;
      step();
      chk("z_rx_oe", z_oe, 4'b0000);
      chk("z_rx_out", z_out, 4'b1111);
      chk("z_rx_rdy", {3'b0, z_rdy}, 4'h1);

      mon_on = 1'b0;
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
